// File: rtl/calc_pkg.sv
// calc_pkg
// Shared definitions for the calculator entry controller: keypad code
// constants, opcode / display-select / FSM state enums and a helper that
// turns an operator key into its opcode.
// Ports: none (package).
package calc_pkg;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_MUL  = 4'hC;
  localparam logic [3:0] KEY_CLR  = 4'hD;
  localparam logic [3:0] KEY_EQ   = 4'hE;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10
  } opcode_t;

  typedef enum logic [1:0] {
    DISP_A   = 2'b00,
    DISP_B   = 2'b01,
    DISP_RES = 2'b10
  } disp_sel_t;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    ISSUE,
    WAIT_RES,
    SHOW_RES
  } state_t;

  // Operator keys A/B/C map onto add/sub/mul; callers only pass operator keys.
  function automatic opcode_t key_to_op(input logic [3:0] key);
    case (key)
      KEY_SUB: key_to_op = OP_SUB;
      KEY_MUL: key_to_op = OP_MUL;
      default: key_to_op = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// key_press_detect
// Turns the level-style scanner code into a one-cycle press strobe. A press
// is a transition from "no key" (4'hF) to any other code; holding a key or
// sliding between codes without releasing produces nothing.
// Ports:
//   clk        - system clock
//   reset      - async active-high reset
//   key_in     - scanner key code, 4'hF when idle
//   press      - registered 1-cycle strobe for a newly pressed key
//   press_code - key code that accompanies the strobe
module key_press_detect
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_in,
  output logic       press,
  output logic [3:0] press_code
);

  logic [3:0] prev_key;

  // prev_key tracks key_in unconditionally so a held key is never re-accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_key   <= KEY_NONE;
      press      <= 1'b0;
      press_code <= KEY_NONE;
    end else begin
      prev_key   <= key_in;
      press      <= (key_in != KEY_NONE) && (prev_key == KEY_NONE);
      press_code <= key_in;
    end
  end

endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl
// Collects operand A, an operator and operand B from keypad presses, hands
// the operation to the arithmetic unit over a valid/ready handshake, waits
// for the result pulse and selects what the display shows.
// Ports:
//   clk        - system clock
//   reset      - async active-high reset
//   key_in     - scanner key code (4'hF = no key)
//   op_ready   - arithmetic unit accepts the operation
//   res_valid  - 1-cycle pulse, result available
//   operand_a  - BCD operand A, MS digit at MSBs
//   operand_b  - BCD operand B
//   opcode     - 00 add, 01 sub, 10 mul
//   op_valid   - operation request
//   disp_sel   - 00 show A, 01 show B, 10 show result
//   busy       - high while issuing or waiting for the result
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS = 3
)(
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          key_in,
  input  logic                op_ready,
  input  logic                res_valid,
  output logic [4*DIGITS-1:0] operand_a,
  output logic [4*DIGITS-1:0] operand_b,
  output logic [1:0]          opcode,
  output logic                op_valid,
  output logic [1:0]          disp_sel,
  output logic                busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

  state_t        state;
  logic [CW-1:0] count_a;
  logic [CW-1:0] count_b;
  logic          press;
  logic [3:0]    press_code;
  logic          is_digit;
  logic          is_op;
  logic          is_clr;
  logic          is_eq;

  key_press_detect u_key_press_detect (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .press      (press),
    .press_code (press_code)
  );

  assign is_digit = press && (press_code <= 4'h9);
  assign is_op    = press && (press_code == KEY_ADD || press_code == KEY_SUB ||
                              press_code == KEY_MUL);
  assign is_clr   = press && (press_code == KEY_CLR);
  assign is_eq    = press && (press_code == KEY_EQ);

  // Single FSM block: every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ENTER_A;
      operand_a <= '0;
      operand_b <= '0;
      count_a   <= '0;
      count_b   <= '0;
      opcode    <= OP_ADD;
      op_valid  <= 1'b0;
      disp_sel  <= DISP_A;
      busy      <= 1'b0;
    end else begin
      case (state)
        ENTER_A: begin
          if (is_clr) begin
            operand_a <= '0;
            operand_b <= '0;
            count_a   <= '0;
            count_b   <= '0;
            opcode    <= OP_ADD;
          end else if (is_digit) begin
            // Saturate at DIGITS: extra digits are dropped rather than shifted out.
            if (count_a != CNT_MAX) begin
              operand_a <= {operand_a[W-5:0], press_code};
              count_a   <= count_a + 1'b1;
            end
          end else if (is_op && count_a != '0) begin
            opcode   <= key_to_op(press_code);
            disp_sel <= DISP_B;
            state    <= ENTER_B;
          end
        end

        ENTER_B: begin
          if (is_clr) begin
            operand_a <= '0;
            operand_b <= '0;
            count_a   <= '0;
            count_b   <= '0;
            opcode    <= OP_ADD;
            disp_sel  <= DISP_A;
            state     <= ENTER_A;
          end else if (is_digit) begin
            if (count_b != CNT_MAX) begin
              operand_b <= {operand_b[W-5:0], press_code};
              count_b   <= count_b + 1'b1;
            end
          end else if (is_op && count_b == '0) begin
            // Operator can still be changed until B has its first digit.
            opcode <= key_to_op(press_code);
          end else if (is_eq && count_b != '0) begin
            op_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= WAIT_RES;
          end
        end

        WAIT_RES: begin
          if (res_valid) begin
            busy     <= 1'b0;
            disp_sel <= DISP_RES;
            state    <= SHOW_RES;
          end
        end

        SHOW_RES: begin
          if (is_clr) begin
            operand_a <= '0;
            operand_b <= '0;
            count_a   <= '0;
            count_b   <= '0;
            opcode    <= OP_ADD;
            disp_sel  <= DISP_A;
            state     <= ENTER_A;
          end else if (is_digit) begin
            // A digit after a result starts a fresh calculation with that digit.
            operand_a <= {{(W-4){1'b0}}, press_code};
            operand_b <= '0;
            count_a   <= CW'(1);
            count_b   <= '0;
            disp_sel  <= DISP_A;
            state     <= ENTER_A;
          end
        end

        default: state <= ENTER_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl
// Self-checking bench for calc_entry_ctrl. Expected operations are queued
// when '=' is keyed and compared when the handshake completes.
module tb_calc_entry_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  key_in;
  logic        op_ready;
  logic        res_valid;
  logic [11:0] operand_a;
  logic [11:0] operand_b;
  logic [1:0]  opcode;
  logic        op_valid;
  logic [1:0]  disp_sel;
  logic        busy;

  int checks;
  int errors;
  int valid_cycles;
  int handshakes;
  logic [25:0] sb_q[$];

  calc_entry_ctrl #(.DIGITS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .op_ready  (op_ready),
    .res_valid (res_valid),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .op_valid  (op_valid),
    .disp_sel  (disp_sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Holds a key for two edges (long enough to be consumed) then releases it.
  task automatic applyStimulus(input logic [3:0] k);
    key_in = k;
    repeat (2) @(posedge clk);
    #1;
    key_in = 4'hF;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard side: compare each accepted operation against the queue.
  always @(negedge clk) begin
    if (!reset && op_valid) begin
      valid_cycles++;
      if (op_ready) begin
        handshakes++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected: got op %0h/%0h/%0h, expected none",
                   operand_a, operand_b, opcode);
        end else begin
          checkOutput("sb_op", {operand_a, operand_b, opcode}, {6'b0, sb_q.pop_front()});
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; valid_cycles = 0; handshakes = 0;
    key_in = 4'hF; op_ready = 1'b0; res_valid = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    $display("[TB] reset state");
    checkOutput("rst_a", operand_a, 12'h000);
    checkOutput("rst_b", operand_b, 12'h000);
    checkOutput("rst_opcode", opcode, 2'b00);
    checkOutput("rst_op_valid", op_valid, 1'b0);
    checkOutput("rst_disp", disp_sel, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);

    $display("[TB] 12 + 3 with op_ready high");
    op_ready = 1'b1;
    applyStimulus(4'hA);
    checkOutput("op_no_a_disp", disp_sel, 2'b00);
    applyStimulus(4'h1);
    applyStimulus(4'h2);
    applyStimulus(4'hA);
    checkOutput("t1_disp_b", disp_sel, 2'b01);
    applyStimulus(4'h3);
    sb_q.push_back({12'h012, 12'h003, 2'b00});
    valid_cycles = 0;
    applyStimulus(4'hE);
    checkOutput("t1_valid_cycles", valid_cycles, 1);
    checkOutput("t1_op_valid", op_valid, 1'b0);
    checkOutput("t1_busy", busy, 1'b1);
    checkOutput("t1_a", operand_a, 12'h012);
    checkOutput("t1_b", operand_b, 12'h003);
    res_valid = 1'b1;
    tick(1);
    res_valid = 1'b0;
    checkOutput("t1_disp_res", disp_sel, 2'b10);
    checkOutput("t1_busy_done", busy, 1'b0);

    $display("[TB] digit saturation");
    op_ready = 1'b0;
    applyStimulus(4'hD);
    checkOutput("clr_disp", disp_sel, 2'b00);
    checkOutput("clr_a", operand_a, 12'h000);
    applyStimulus(4'h9);
    applyStimulus(4'h8);
    applyStimulus(4'h7);
    applyStimulus(4'h6);
    checkOutput("sat_a", operand_a, 12'h987);

    $display("[TB] held key");
    applyStimulus(4'hD);
    key_in = 4'h5;
    tick(1000);
    key_in = 4'h3;
    tick(3);
    key_in = 4'hF;
    tick(2);
    checkOutput("hold_a", operand_a, 12'h005);

    $display("[TB] stray res_valid in ENTER_A");
    res_valid = 1'b1;
    tick(1);
    res_valid = 1'b0;
    tick(1);
    checkOutput("stray_res_disp", disp_sel, 2'b00);

    $display("[TB] 4 * 2 with op_ready low");
    applyStimulus(4'hD);
    applyStimulus(4'h4);
    applyStimulus(4'hC);
    applyStimulus(4'h2);
    sb_q.push_back({12'h004, 12'h002, 2'b10});
    applyStimulus(4'hE);
    for (int i = 0; i < 20; i++) begin
      if (i == 8) applyStimulus(4'hD);
      checkOutput("stall_op_valid", op_valid, 1'b1);
      checkOutput("stall_op", {operand_a, operand_b, opcode}, {12'h004, 12'h002, 2'b10});
      tick(1);
    end
    checkOutput("stall_busy", busy, 1'b1);
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    checkOutput("stall_drop", op_valid, 1'b0);
    checkOutput("stall_wait_busy", busy, 1'b1);
    applyStimulus(4'h1);
    checkOutput("wait_ignores_key", operand_a, 12'h004);
    res_valid = 1'b1;
    tick(1);
    res_valid = 1'b0;
    checkOutput("t4_disp_res", disp_sel, 2'b10);
    applyStimulus(4'h7);
    checkOutput("new_a", operand_a, 12'h007);
    checkOutput("new_b", operand_b, 12'h000);
    checkOutput("new_disp", disp_sel, 2'b00);
    applyStimulus(4'h8);
    checkOutput("new_a_cont", operand_a, 12'h078);

    $display("[TB] reset during ISSUE");
    applyStimulus(4'hD);
    applyStimulus(4'h1);
    applyStimulus(4'hB);
    applyStimulus(4'h1);
    applyStimulus(4'hE);
    checkOutput("pre_rst_valid", op_valid, 1'b1);
    checkOutput("pre_rst_opcode", opcode, 2'b01);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_op_valid", op_valid, 1'b0);
    checkOutput("async_busy", busy, 1'b0);
    checkOutput("async_a", operand_a, 12'h000);
    checkOutput("async_b", operand_b, 12'h000);
    checkOutput("async_opcode", opcode, 2'b00);
    checkOutput("async_disp", disp_sel, 2'b00);
    tick(2);
    reset = 1'b0;
    tick(2);
    checkOutput("post_rst_valid", op_valid, 1'b0);
    applyStimulus(4'h6);
    checkOutput("post_rst_a", operand_a, 12'h006);

    checkOutput("handshakes", handshakes, 2);
    checkOutput("sb_leftover", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
